// File: rtl/ccu_pkg.sv
// ccu_pkg: shared types and constants for the cache control unit
package procyon_ccu_pkg;
  localparam int CCU_ADDR_WIDTH = 32;
  localparam int CCU_LINE_SIZE = 32;
  localparam int CCU_LINE_OFFSET_W = $clog2(CCU_LINE_SIZE);
  typedef enum logic [2:0] {IDLE, WB, WB_GAP, FILL, RESP} ccu_state_t;
  typedef enum logic {CCU_REQ_IC, CCU_REQ_DC} ccu_req_t;
endpackage

// File: rtl/ccu_if.sv
// ccu_if: line-sized BIU bus between the ccu (master) and the bus interface unit (slave)
interface ccu_if import procyon_ccu_pkg::*; #(
  parameter int OPTN_ADDR_WIDTH = CCU_ADDR_WIDTH,
  parameter int OPTN_DC_LINE_SIZE = CCU_LINE_SIZE
) ();
  localparam int DC_LINE_WIDTH = OPTN_DC_LINE_SIZE * 8;
  logic o_biu_en;
  logic o_biu_we;
  logic [OPTN_ADDR_WIDTH-1:0] o_biu_addr;
  logic [DC_LINE_WIDTH-1:0] o_biu_data;
  logic [DC_LINE_WIDTH-1:0] i_biu_data;
  logic i_biu_busy;
  logic i_biu_done;
  modport master (
    output o_biu_en, o_biu_we, o_biu_addr, o_biu_data,
    input i_biu_data, i_biu_busy, i_biu_done
  );
  modport slave (
    input o_biu_en, o_biu_we, o_biu_addr, o_biu_data,
    output i_biu_data, i_biu_busy, i_biu_done
  );
endinterface

// File: rtl/ccu_rr_arb.sv
// ccu_rr_arb: 2-way round-robin arbiter (bit 0 = I$, bit 1 = D$), one-hot grant
module ccu_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic fav_dc_q, fav_dc_d;
  assign gnt = {req[1] & (~req[0] | fav_dc_q), req[0] & (~req[1] | ~fav_dc_q)};
  always_comb fav_dc_d = accept && |req ? gnt[0] : fav_dc_q;
  always_ff @(posedge clk) fav_dc_q <= rst ? 1'b1 : fav_dc_d;
endmodule

// File: rtl/ccu.sv
// ccu: serialises I$/D$ line fills and D$ victim writebacks onto the single BIU
module ccu import procyon_ccu_pkg::*; #(
  parameter int OPTN_ADDR_WIDTH = CCU_ADDR_WIDTH,
  parameter int OPTN_DC_LINE_SIZE = CCU_LINE_SIZE,
  localparam int DC_LINE_WIDTH = OPTN_DC_LINE_SIZE * 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_ic_req,
  input  logic [OPTN_ADDR_WIDTH-1:0] i_ic_addr,
  output logic                       o_ic_ack,
  output logic [DC_LINE_WIDTH-1:0]   o_ic_data,
  input  logic                       i_dc_req,
  input  logic [OPTN_ADDR_WIDTH-1:0] i_dc_addr,
  input  logic                       i_dc_victim_valid,
  input  logic [OPTN_ADDR_WIDTH-1:0] i_dc_victim_addr,
  input  logic [DC_LINE_WIDTH-1:0]   i_dc_victim_data,
  output logic                       o_dc_ack,
  output logic [DC_LINE_WIDTH-1:0]   o_dc_data,
  ccu_if.master                      biu
);
  localparam int OFF_W = $clog2(OPTN_DC_LINE_SIZE);
  localparam logic [OPTN_ADDR_WIDTH-1:0] ALIGN_MASK = {OPTN_ADDR_WIDTH{1'b1}} << OFF_W;
  ccu_state_t state_q, state_d;
  ccu_req_t id_q, id_d;
  logic [OPTN_ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d, vic_addr_q, vic_addr_d;
  logic [DC_LINE_WIDTH-1:0] vic_data_q, vic_data_d, resp_q, resp_d;
  logic [1:0] gnt;
  logic unused_busy;
  assign unused_busy = biu.i_biu_busy;
  ccu_rr_arb u_arb (
    .clk(i_clk),
    .rst(i_reset),
    .req({i_dc_req, i_ic_req}),
    .accept(state_q == IDLE),
    .gnt(gnt)
  );
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    fill_addr_d = fill_addr_q;
    vic_addr_d = vic_addr_q;
    vic_data_d = vic_data_q;
    resp_d = resp_q;
    case (state_q)
      IDLE: if (|gnt) begin
        id_d = gnt[1] ? CCU_REQ_DC : CCU_REQ_IC;
        fill_addr_d = (gnt[1] ? i_dc_addr : i_ic_addr) & ALIGN_MASK;
        vic_addr_d = gnt[1] ? i_dc_victim_addr & ALIGN_MASK : vic_addr_q;
        vic_data_d = gnt[1] ? i_dc_victim_data : vic_data_q;
        state_d = gnt[1] && i_dc_victim_valid ? WB : FILL;
      end
      WB: state_d = biu.i_biu_done ? WB_GAP : WB;
      WB_GAP: state_d = FILL;
      FILL: begin
        resp_d = biu.i_biu_done ? biu.i_biu_data : resp_q;
        state_d = biu.i_biu_done ? RESP : FILL;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      id_q <= CCU_REQ_IC;
      fill_addr_q <= '0;
      vic_addr_q <= '0;
      vic_data_q <= '0;
      resp_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      fill_addr_q <= fill_addr_d;
      vic_addr_q <= vic_addr_d;
      vic_data_q <= vic_data_d;
      resp_q <= resp_d;
    end
  end
  assign biu.o_biu_en = state_q == WB || state_q == FILL;
  assign biu.o_biu_we = state_q == WB;
  assign biu.o_biu_addr = state_q == WB ? vic_addr_q : fill_addr_q;
  assign biu.o_biu_data = vic_data_q;
  assign o_ic_ack = state_q == RESP && id_q == CCU_REQ_IC;
  assign o_dc_ack = state_q == RESP && id_q == CCU_REQ_DC;
  assign o_ic_data = resp_q;
  assign o_dc_data = resp_q;
endmodule

// File: tb/tb_ccu.sv
// tb_ccu: directed-vector bench for ccu with a hand-driven BIU
module tb_ccu;
  typedef logic [255:0] line_t;
  logic i_clk, i_reset, i_ic_req, i_dc_req, i_dc_victim_valid, o_ic_ack, o_dc_ack;
  logic [31:0] i_ic_addr, i_dc_addr, i_dc_victim_addr;
  line_t i_dc_victim_data, o_ic_data, o_dc_data;
  int n_vec = 0;
  int n_bad = 0;
  ccu_if biu ();
  ccu dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_ic_req(i_ic_req),
    .i_ic_addr(i_ic_addr),
    .o_ic_ack(o_ic_ack),
    .o_ic_data(o_ic_data),
    .i_dc_req(i_dc_req),
    .i_dc_addr(i_dc_addr),
    .i_dc_victim_valid(i_dc_victim_valid),
    .i_dc_victim_addr(i_dc_victim_addr),
    .i_dc_victim_data(i_dc_victim_data),
    .o_dc_ack(o_dc_ack),
    .o_dc_data(o_dc_data),
    .biu(biu)
  );
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input line_t got, input line_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge i_clk);
  endtask
  task automatic phase(input string tag, input logic we, input logic [31:0] addr,
                       input line_t wdata, input line_t rdata, input int lat);
    for (int i = 0; i <= lat; i++) begin
      check({tag, "_en"}, 256'(biu.o_biu_en), 256'(1));
      check({tag, "_we"}, 256'(biu.o_biu_we), 256'(we));
      check({tag, "_addr"}, 256'(biu.o_biu_addr), 256'(addr));
      if (we) check({tag, "_wdata"}, biu.o_biu_data, wdata);
      if (i == lat) begin
        biu.i_biu_done = 1'b1;
        biu.i_biu_data = rdata;
      end
      cyc();
    end
    biu.i_biu_done = 1'b0;
    biu.i_biu_data = '0;
    check({tag, "_release"}, 256'(biu.o_biu_en), 256'(0));
  endtask
  task automatic fill_ack(input string tag, input logic dc, input logic [31:0] addr,
                          input line_t rdata, input int lat);
    phase(tag, 1'b0, addr, '0, rdata, lat);
    check({tag, "_ic_ack"}, 256'(o_ic_ack), 256'(!dc));
    check({tag, "_dc_ack"}, 256'(o_dc_ack), 256'(dc));
    check({tag, "_data"}, dc ? o_dc_data : o_ic_data, rdata);
    if (dc) i_dc_req = 1'b0;
    else i_ic_req = 1'b0;
    cyc();
    check({tag, "_ack_drop"}, 256'({o_ic_ack, o_dc_ack}), 256'(0));
    check({tag, "_idle_en"}, 256'(biu.o_biu_en), 256'(0));
  endtask
  task automatic do_reset();
    i_reset = 1'b1;
    cyc();
    cyc();
    i_reset = 1'b0;
  endtask
  initial begin
    i_reset = 1'b1;
    i_ic_req = 1'b0;
    i_dc_req = 1'b0;
    i_dc_victim_valid = 1'b0;
    i_ic_addr = '0;
    i_dc_addr = '0;
    i_dc_victim_addr = '0;
    i_dc_victim_data = '0;
    biu.i_biu_data = '0;
    biu.i_biu_done = 1'b0;
    biu.i_biu_busy = 1'b0;
    do_reset();
    check("rst_en", 256'(biu.o_biu_en), 256'(0));
    check("rst_we", 256'(biu.o_biu_we), 256'(0));
    check("rst_acks", 256'({o_ic_ack, o_dc_ack}), 256'(0));
    check("rst_addr", 256'(biu.o_biu_addr), 256'(0));
    check("rst_wdata", biu.o_biu_data, '0);
    check("rst_resp", o_ic_data, '0);
    i_ic_req = 1'b1;
    i_ic_addr = 32'h0000_1004;
    cyc();
    fill_ack("ic_only", 1'b0, 32'h0000_1000, {8{32'hA1A1_0001}}, 2);
    i_dc_req = 1'b1;
    i_dc_addr = 32'h0000_3000;
    i_dc_victim_valid = 1'b1;
    i_dc_victim_addr = 32'h0000_2004;
    i_dc_victim_data = {8{32'hDEAD_BEEF}};
    cyc();
    phase("dc_wb", 1'b1, 32'h0000_2000, {8{32'hDEAD_BEEF}}, '0, 1);
    check("dc_wb_gap_ack", 256'({o_ic_ack, o_dc_ack}), 256'(0));
    cyc();
    fill_ack("dc_vic_fill", 1'b1, 32'h0000_3000, {8{32'hB2B2_0002}}, 0);
    i_dc_victim_valid = 1'b0;
    i_dc_req = 1'b1;
    i_dc_addr = 32'h0000_403C;
    cyc();
    i_dc_addr = 32'h0000_5000;
    i_dc_victim_valid = 1'b1;
    fill_ack("dc_novic", 1'b1, 32'h0000_4020, {8{32'hC3C3_0003}}, 1);
    i_dc_victim_valid = 1'b0;
    i_ic_req = 1'b1;
    i_ic_addr = 32'h0000_0100;
    i_dc_req = 1'b1;
    i_dc_addr = 32'h0000_0200;
    cyc();
    fill_ack("tie_ic", 1'b0, 32'h0000_0100, {8{32'hD4D4_0004}}, 0);
    cyc();
    fill_ack("tie_dc2", 1'b1, 32'h0000_0200, {8{32'hE5E5_0005}}, 0);
    do_reset();
    i_ic_req = 1'b1;
    i_dc_req = 1'b1;
    cyc();
    fill_ack("rst_tie_dc", 1'b1, 32'h0000_0200, {8{32'hF6F6_0006}}, 0);
    cyc();
    fill_ack("rst_tie_ic", 1'b0, 32'h0000_0100, {8{32'h1717_0007}}, 0);
    i_ic_req = 1'b1;
    i_ic_addr = 32'h0000_6000;
    cyc();
    check("abort_en", 256'(biu.o_biu_en), 256'(1));
    biu.i_biu_done = 1'b1;
    biu.i_biu_data = {8{32'h2828_0008}};
    i_reset = 1'b1;
    cyc();
    check("abort_en_off", 256'(biu.o_biu_en), 256'(0));
    check("abort_acks", 256'({o_ic_ack, o_dc_ack}), 256'(0));
    check("abort_resp", o_ic_data, '0);
    i_reset = 1'b0;
    biu.i_biu_done = 1'b0;
    biu.i_biu_data = '0;
    cyc();
    fill_ack("abort_refill", 1'b0, 32'h0000_6000, {8{32'h3939_0009}}, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ccu.md
# ccu

Cache control unit arbitrating line-sized memory traffic from the instruction cache (fills) and data cache (fills with optional dirty-victim writeback) onto the single Wishbone bus interface unit (BIU). Sits between the L1 caches and the BIU. Serialises requests, sequences writeback-then-fill, follows the BIU's `en`/`done` handshake, and returns the fetched line to the winning requester with a one-cycle ack.

## Interface
- `OPTN_ADDR_WIDTH`, 32, physical address width
- `OPTN_DC_LINE_SIZE`, 32, line size in bytes (shared by I$ and D$)
- `DC_LINE_WIDTH`, `OPTN_DC_LINE_SIZE*8`, line width in bits (derived)

Ports (one clock; reset synchronous, active-high):
- `i_clk` in 1: clock
- `i_reset` in 1: synchronous active-high reset
- `i_ic_req` in 1: I$ fill request, held until `o_ic_ack`
- `i_ic_addr` in `OPTN_ADDR_WIDTH`: I$ fill address
- `o_ic_ack` out 1: one-cycle pulse, `o_ic_data` valid
- `o_ic_data` out `DC_LINE_WIDTH`: filled line
- `i_dc_req` in 1: D$ fill request, held until `o_dc_ack`
- `i_dc_addr` in `OPTN_ADDR_WIDTH`: D$ fill address
- `i_dc_victim_valid` in 1: dirty victim must be written back first
- `i_dc_victim_addr` in `OPTN_ADDR_WIDTH`: victim line address
- `i_dc_victim_data` in `DC_LINE_WIDTH`: victim line data
- `o_dc_ack` out 1: one-cycle pulse, `o_dc_data` valid
- `o_dc_data` out `DC_LINE_WIDTH`: filled line
- `o_biu_en` out 1: BIU transaction enable
- `o_biu_we` out 1: 1 = line write, 0 = line read
- `o_biu_addr` out `OPTN_ADDR_WIDTH`: line-aligned address
- `o_biu_data` out `DC_LINE_WIDTH`: write data
- `i_biu_data` in `DC_LINE_WIDTH`: read data, valid when `i_biu_done`
- `i_biu_busy` in 1: BIU mid-transaction (monitor only)
- `i_biu_done` in 1: BIU transaction complete; held until `o_biu_en` drops

## Operation
- States: IDLE, WB, WB_GAP, FILL, RESP.
- IDLE: if any request, grant via 2-way round-robin (tie → requester not granted last; after reset D$ wins first tie). At grant, latch requester id, fill address, victim valid/addr/data. Next: WB if D$ with victim valid, else FILL.
- All addresses to BIU forced line-aligned: low `$clog2(OPTN_DC_LINE_SIZE)` bits zeroed.
- WB: `o_biu_en`=1, `o_biu_we`=1, addr/data = latched victim. On `i_biu_done` → WB_GAP.
- WB_GAP: `o_biu_en`=0 for exactly one cycle (releases BIU to idle) → FILL.
- FILL: `o_biu_en`=1, `o_biu_we`=0, addr = latched fill address. On `i_biu_done` latch `i_biu_data` into response register → RESP.
- RESP: `o_biu_en`=0; assert ack of granted requester only; → IDLE.
- `o_ic_data`/`o_dc_data` both driven from the one response register; meaningful only during own ack.
- Requester must drop `req` the cycle after ack; requests sampled in RESP are ignored. Request/address changes after grant have no effect.
- Non-granted request stays pending; never dropped.

## Timing
- Reset: state IDLE; `o_biu_en`, `o_biu_we`, `o_ic_ack`, `o_dc_ack` = 0; latched addr/data/response registers = 0; round-robin pointer = favour D$. Reset mid-transaction aborts immediately (BIU shares reset).
- Grant: request seen in IDLE at cycle t → `o_biu_en`=1 at t+1.
- `i_biu_done` in FILL at cycle k → ack at k+1; IDLE at k+2; next grant's `o_biu_en` earliest k+3.
- `i_biu_done` in WB at cycle k → WB_GAP at k+1 → FILL (`o_biu_en`=1, `we`=0) at k+2.
- Simultaneous I$/D$ requests: one served fully (including writeback) before the other; alternation guaranteed.
- `o_biu_we`, `o_biu_addr`, `o_biu_data` stable throughout any cycle with `o_biu_en`=1.
- `i_biu_done` outside WB/FILL ignored.

## Structure
- Package `procyon_ccu_pkg`: state enum `ccu_state_t`, requester id enum (`CCU_REQ_IC`, `CCU_REQ_DC`), line-offset width constant.
- Sub-module `ccu_rr_arb`: 2-input round-robin arbiter, one-hot grant, pointer updated on accepted grant.

## Test plan
- I$ only, `i_ic_addr`=0x1004: BIU sees en=1, we=0, addr=0x1000 one cycle after request; on done, `o_ic_ack` pulses one cycle with returned line; `o_dc_ack` stays 0.
- D$ with victim (victim 0x2000, fill 0x3000): write to 0x2000 with victim data, exactly one en=0 cycle, read of 0x3000, then `o_dc_ack` with read data.
- D$ without victim: no write phase; single read, ack at done+1.
- I$ and D$ asserted same cycle after reset: D$ served first, then I$; repeated simultaneous pairs alternate.
- Reset asserted during FILL with `i_biu_done` pending: next cycle en=0, acks 0, IDLE; held request re-served from scratch after reset.
- Request changes address after grant: BIU address remains latched value; ack carries data for original address.
